pio_sm_ctrl: RTL and testbench
==============================

# pio_sm_ctrl

Per-state-machine sequencing controller for the PIO block. It generates the `penable` step strobe for each PIO state machine's program counter from a 16.8 fractional clock divider. It also issues one-cycle `sm_reset` pulses on restart and injects immediate (forced) instructions through a valid/ready port. It sits between the PIO register file and the NUM_SM state-machine instances, driving their `penable`, `reset` and `imm` inputs.

## Interface

- NUM_SM, 4, number of state machines controlled; legal values 2, 4, 8.
- SMW, $clog2(NUM_SM), width of the state-machine select field.

- clk  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- en  in  NUM_SM  per-SM enable (level, register-file sourced).
- div_int  in  16*NUM_SM  integer divisor per SM, SM i at [16i+15:16i]; 0 means 65536.
- div_frac  in  8*NUM_SM  fractional divisor per SM in 1/256 units, SM i at [8i+7:8i].
- restart_stb  in  NUM_SM  one-cycle strobe to restart SM i (pc reset plus divider restart).
- clkdiv_restart_stb  in  NUM_SM  one-cycle strobe to restart the dividers of the selected SMs only.
- stalled  in  NUM_SM  per-SM stall status from the SM datapath.
- imm_valid  in  1  immediate-instruction request.
- imm_sm  in  SMW  target SM of the request.
- imm_instr  in  16  instruction to inject.
- imm_ready  out  1  controller can accept a request.
- penable  out  NUM_SM  per-SM step strobe.
- sm_reset  out  NUM_SM  per-SM synchronous reset pulse to the pc/SM.
- imm  out  NUM_SM  per-SM immediate-execute qualifier (one-hot or zero).
- imm_instr_o  out  16  held copy of the accepted instruction.

## Operation

- Per-SM divider state:
  - `cnt` is 17 bits; reset value 1.
  - `acc` is 8 bits; reset value 0.
- `penable[i] = en[i] && cnt_i==1 && !sm_reset[i] && !imm[i]`.
  - It is decoded from flops and inputs; no other terms.
- Divider step, while en[i]=1:
  - If cnt_i==1: {carry, acc_i} <= acc_i + div_frac_i; cnt_i <= D + carry, where D = div_int_i, or 65536 if div_int_i==0.
  - Otherwise: cnt_i <= cnt_i - 1.
- en[i]=0: cnt_i and acc_i hold; penable[i]=0.
- The divider runs independently of stalled. Stall gating is done in the pc.
- Divisor changes mid-period take effect at the next reload; the current count is not disturbed.
- Divide 1.0 yields penable every enabled cycle. Divide 1.5 alternates periods of 1 and 2 cycles.
- restart_stb[i] at edge T:
  - sm_reset[i]=1 for exactly cycle T+1.
  - cnt_i <= 1 and acc_i <= 0 at edge T.
  - penable[i] is forced 0 in cycle T+1.
- clkdiv_restart_stb[i] at edge T: cnt_i <= 1, acc_i <= 0; sm_reset is untouched.
  - It overrides a same-cycle divider step.
  - Dividers of all SMs strobed in the same cycle emit their next penable together.
- Immediate injection has two states, IDLE and HOLD:
  - IDLE: imm_ready=1. A handshake (imm_valid && imm_ready) at edge T latches imm_sm and imm_instr and moves to HOLD.
  - HOLD: imm_ready=0; imm[t]=1; imm_instr_o holds the latched value.
  - HOLD exits to IDLE at the first edge where stalled[t]==0 and sm_reset[t]==0. The instruction executes in that cycle.
  - While sm_reset[t]=1, HOLD persists; the request is retried after the reset pulse.
- imm executes regardless of en[t]. While imm[t]=1, penable[t] is forced 0, so no double step occurs.
- Reset (resetn low, asynchronous):
  - All cnt=1, acc=0.
  - State IDLE: imm_ready=1 and imm=0.
  - penable=0, sm_reset=0, imm_instr_o=0.
  - Effect is immediate, including mid-HOLD; the pending request is discarded.

## Timing

- Latency from en rising to first penable: 0 cycles after reset or restart, because cnt==1.
- restart_stb to sm_reset: 1 cycle. sm_reset width: exactly 1 cycle.
- Handshake at edge T gives imm[t] high from cycle T+1.
  - If unstalled, imm drops at T+2 and imm_ready rises at T+2.
  - Maximum injection throughput: 1 per 2 cycles.
- Divider period = floor or ceil of (div_int + div_frac/256) cycles. The long-run average is exact over 256 periods.
- Simultaneous events on the same SM, highest priority first:
  - restart_stb
  - clkdiv_restart_stb
  - divider step

## Test plan

- Divider values: en[0]=1, div_int=3, frac=0 -> penable[0] high every 3rd cycle, first in cycle 0. div_int=1, frac=128 -> gaps alternate 1,2. div_int=0 -> period 65536.
- Enable gating: drop en mid-period at cnt=2, hold 10 cycles, re-enable -> penable resumes exactly 1 enabled cycle later, with no lost or extra pulse.
- Restart: restart_stb[1] while cnt=5 -> sm_reset[1] high 1 cycle with penable[1]=0 -> next enabled cycle gives penable[1]=1. Simultaneous clkdiv_restart_stb=4'b1111 with different divisors -> all penables coincident next cycle.
- Immediate injection: imm_sm=2 with stalled[2]=1 for 3 cycles -> imm[2] held 4 cycles, imm_ready low throughout, penable[2]=0, imm_instr_o stable. Unstalled back-to-back requests -> one accepted per 2 cycles.
- Reset mid-operation: resetn low during HOLD -> imm=0, imm_ready=1 immediately; after release, cnt=1 and the first penable is in the first enabled cycle.

Source files
------------

// File: rtl/pio_sm_ctrl.sv
// Per-SM sequencing controller: fractional clock dividers that produce penable,
// restart pulses, and a single-slot immediate-instruction injector.
module pio_sm_ctrl #(
    parameter int NUM_SM = 4,
    parameter int SMW    = $clog2(NUM_SM)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_SM-1:0]    en,
    input  logic [16*NUM_SM-1:0] div_int,
    input  logic [8*NUM_SM-1:0]  div_frac,
    input  logic [NUM_SM-1:0]    restart_stb,
    input  logic [NUM_SM-1:0]    clkdiv_restart_stb,
    input  logic [NUM_SM-1:0]    stalled,
    input  logic                 imm_valid,
    input  logic [SMW-1:0]       imm_sm,
    input  logic [15:0]          imm_instr,
    output logic                 imm_ready,
    output logic [NUM_SM-1:0]    penable,
    output logic [NUM_SM-1:0]    sm_reset,
    output logic [NUM_SM-1:0]    imm,
    output logic [15:0]          imm_instr_o
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SMW-1:0]     imm_sm_q, imm_sm_d;
    logic [15:0]        imm_instr_q, imm_instr_d;
    logic [NUM_SM-1:0]  sm_reset_q, sm_reset_d;

    assign imm_ready   = (state_q == IDLE);
    assign imm_instr_o = imm_instr_q;
    assign sm_reset    = sm_reset_q;

    always_comb begin
        sm_reset_d = restart_stb;
    end

    // Immediate injector: a request parks in HOLD until its target SM is
    // neither stalled nor in its reset pulse; that cycle executes it.
    always_comb begin
        state_d     = state_q;
        imm_sm_d    = imm_sm_q;
        imm_instr_d = imm_instr_q;
        case (state_q)
            IDLE: begin
                if (imm_valid) begin
                    state_d     = HOLD;
                    imm_sm_d    = imm_sm;
                    imm_instr_d = imm_instr;
                end
            end
            HOLD: begin
                if (!stalled[imm_sm_q] && !sm_reset_q[imm_sm_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            imm_sm_q    <= '0;
            imm_instr_q <= '0;
            sm_reset_q  <= '0;
        end else begin
            state_q     <= state_d;
            imm_sm_q    <= imm_sm_d;
            imm_instr_q <= imm_instr_d;
            sm_reset_q  <= sm_reset_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SM; gi++) begin : g_div
            logic [16:0] cnt_q, cnt_d;
            logic [7:0]  acc_q, acc_d;
            logic [8:0]  frac_sum;
            logic [16:0] period;
            logic        cnt_is_one;

            assign frac_sum   = {1'b0, acc_q} + {1'b0, div_frac[8*gi +: 8]};
            assign period     = (div_int[16*gi +: 16] == 16'd0) ? 17'h10000
                                                                 : {1'b0, div_int[16*gi +: 16]};
            assign cnt_is_one = (cnt_q == 17'd1);

            assign imm[gi]     = (state_q == HOLD) && (imm_sm_q == SMW'(gi));
            // resetn term keeps penable low while reset is held, even though cnt rests at 1
            assign penable[gi] = resetn && en[gi] && cnt_is_one && !sm_reset_q[gi] && !imm[gi];

            // The divider is frozen during the sm_reset cycle so the restarted
            // SM steps on its first cycle out of reset.
            always_comb begin
                cnt_d = cnt_q;
                acc_d = acc_q;
                if (restart_stb[gi] || clkdiv_restart_stb[gi]) begin
                    cnt_d = 17'd1;
                    acc_d = 8'd0;
                end else if (en[gi] && !sm_reset_q[gi]) begin
                    if (cnt_is_one) begin
                        cnt_d = period + {16'd0, frac_sum[8]};
                        acc_d = frac_sum[7:0];
                    end else begin
                        cnt_d = cnt_q - 17'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_q <= 17'd1;
                    acc_q <= 8'd0;
                end else begin
                    cnt_q <= cnt_d;
                    acc_q <= acc_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pio_sm_ctrl.sv
// Self-checking bench for pio_sm_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pio_sm_ctrl;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [N-1:0]     en;
    logic [16*N-1:0]  div_int;
    logic [8*N-1:0]   div_frac;
    logic [N-1:0]     restart_stb;
    logic [N-1:0]     clkdiv_restart_stb;
    logic [N-1:0]     stalled;
    logic             imm_valid;
    logic [1:0]       imm_sm;
    logic [15:0]      imm_instr;
    logic             imm_ready;
    logic [N-1:0]     penable;
    logic [N-1:0]     sm_reset;
    logic [N-1:0]     imm;
    logic [15:0]      imm_instr_o;

    int errors = 0;
    int checks = 0;

    pio_sm_ctrl #(.NUM_SM(N)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .en                 (en),
        .div_int            (div_int),
        .div_frac           (div_frac),
        .restart_stb        (restart_stb),
        .clkdiv_restart_stb (clkdiv_restart_stb),
        .stalled            (stalled),
        .imm_valid          (imm_valid),
        .imm_sm             (imm_sm),
        .imm_instr          (imm_instr),
        .imm_ready          (imm_ready),
        .penable            (penable),
        .sm_reset           (sm_reset),
        .imm                (imm),
        .imm_instr_o        (imm_instr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_rem = enabled cycles left before the next pulse
    // (0 means a pulse is due now); m_acc = fractional remainder in 1/256.
    int          m_rem [N];
    int          m_acc [N];
    logic [N-1:0] m_srst;
    logic        m_hold;
    int          m_t;
    logic [15:0] m_instr;

    function automatic int per(input int i);
        int d;
        d = int'(div_int[16*i +: 16]);
        return (d == 0) ? 65536 : d;
    endfunction

    function automatic int fsum(input int i);
        return m_acc[i] + int'(div_frac[8*i +: 8]);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                m_rem[i] <= 0;
                m_acc[i] <= 0;
            end
            m_srst  <= '0;
            m_hold  <= 1'b0;
            m_t     <= 0;
            m_instr <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (restart_stb[i] || clkdiv_restart_stb[i]) begin
                    m_rem[i] <= 0;
                    m_acc[i] <= 0;
                end else if (en[i] && !m_srst[i]) begin
                    if (m_rem[i] == 0) begin
                        m_rem[i] <= per(i) + fsum(i) / 256 - 1;
                        m_acc[i] <= fsum(i) % 256;
                    end else begin
                        m_rem[i] <= m_rem[i] - 1;
                    end
                end
            end
            if (m_hold) begin
                if (!stalled[m_t] && !m_srst[m_t]) m_hold <= 1'b0;
            end else if (imm_valid) begin
                m_hold  <= 1'b1;
                m_t     <= int'(imm_sm);
                m_instr <= imm_instr;
            end
            m_srst <= restart_stb;
        end
    end

    function automatic logic [N-1:0] exp_imm();
        logic [N-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) e[i] = m_hold && (m_t == i);
        return e;
    endfunction

    function automatic logic [N-1:0] exp_pen();
        logic [N-1:0] e;
        logic [N-1:0] im;
        im = exp_imm();
        e = '0;
        for (int i = 0; i < N; i++)
            e[i] = resetn && en[i] && (m_rem[i] == 0) && !m_srst[i] && !im[i];
        return e;
    endfunction

    always @(negedge clk) begin
        chk("penable", 64'(penable), 64'(exp_pen()));
        chk("sm_reset", 64'(sm_reset), 64'(m_srst));
        chk("imm", 64'(imm), 64'(exp_imm()));
        chk("imm_ready", 64'(imm_ready), 64'(!m_hold));
        chk("imm_instr_o", 64'(imm_instr_o), 64'(m_instr));
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        int hs;
        int gap;

        en = '1; div_int = '0; div_frac = '0; restart_stb = '0;
        clkdiv_restart_stb = '0; stalled = '0; imm_valid = 1'b0;
        imm_sm = '0; imm_instr = '0;

        // Reset state: en high but penable must stay low while resetn is low
        repeat (2) @(negedge clk);
        chk("rst_imm_ready", 64'(imm_ready), 64'd1);
        chk("rst_penable", 64'(penable), 64'd0);
        chk("rst_imm", 64'(imm), 64'd0);
        chk("rst_sm_reset", 64'(sm_reset), 64'd0);
        chk("rst_imm_instr_o", 64'(imm_instr_o), 64'd0);

        // Divide by 3: pulse in cycle 0, then every 3rd cycle
        next();
        resetn = 1'b1;
        en = 4'b0001;
        div_int[15:0] = 16'd3;
        pat = 6'b001001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("div3_c%0d", k), 64'(penable[0]), 64'(pat[k]));
            next();
        end

        // Divide by 1.5: gaps alternate 1,2
        div_int[15:0] = 16'd1; div_frac[7:0] = 8'd128; clkdiv_restart_stb = 4'b0001;
        next();
        clkdiv_restart_stb = '0;
        pat = 6'b011011;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("div1p5_c%0d", k), 64'(penable[0]), 64'(pat[k]));
            next();
        end

        // Enable gating at cnt=2
        div_int[15:0] = 16'd4; div_frac[7:0] = 8'd0; clkdiv_restart_stb = 4'b0001;
        next();
        clkdiv_restart_stb = '0;
        @(negedge clk); chk("gate_first", 64'(penable[0]), 64'd1); next();
        repeat (2) begin @(negedge clk); chk("gate_mid", 64'(penable[0]), 64'd0); next(); end
        en[0] = 1'b0;
        repeat (10) begin @(negedge clk); chk("gate_off", 64'(penable[0]), 64'd0); next(); end
        en[0] = 1'b1;
        @(negedge clk); chk("gate_resume0", 64'(penable[0]), 64'd0); next();
        @(negedge clk); chk("gate_resume1", 64'(penable[0]), 64'd1); next();

        // Restart SM1 while its count is 5
        div_int[31:16] = 16'd8; en = 4'b0011; clkdiv_restart_stb = 4'b0010;
        next();
        clkdiv_restart_stb = '0;
        repeat (4) next();
        restart_stb = 4'b0010;
        next();
        restart_stb = '0;
        @(negedge clk);
        chk("restart_srst", 64'(sm_reset[1]), 64'd1);
        chk("restart_pen_masked", 64'(penable[1]), 64'd0);
        next();
        @(negedge clk);
        chk("restart_srst_gone", 64'(sm_reset[1]), 64'd0);
        chk("restart_pen_next", 64'(penable[1]), 64'd1);
        next();

        // Simultaneous divider restart with different divisors
        en = 4'hF;
        div_int = {16'd7, 16'd5, 16'd2, 16'd9};
        div_frac = {8'd17, 8'd200, 8'd3, 8'd99};
        clkdiv_restart_stb = 4'hF;
        next();
        clkdiv_restart_stb = '0;
        @(negedge clk); chk("cdr_coincident", 64'(penable), 64'hF); next();

        // Immediate to SM2 stalled for 3 cycles: imm held 4 cycles
        stalled = 4'b0100; imm_valid = 1'b1; imm_sm = 2'd2; imm_instr = 16'hABCD;
        next();
        imm_valid = 1'b0; imm_instr = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) stalled = '0;
            @(negedge clk);
            chk("hold_imm", 64'(imm), 64'h4);
            chk("hold_ready", 64'(imm_ready), 64'd0);
            chk("hold_pen2", 64'(penable[2]), 64'd0);
            chk("hold_instr", 64'(imm_instr_o), 64'hABCD);
            next();
        end
        @(negedge clk);
        chk("hold_done_imm", 64'(imm), 64'd0);
        chk("hold_done_ready", 64'(imm_ready), 64'd1);
        next();

        // Back-to-back unstalled requests: one accepted per 2 cycles
        imm_valid = 1'b1; hs = 0;
        for (int k = 0; k < 8; k++) begin
            imm_sm = 2'($urandom_range(3));
            imm_instr = 16'($urandom);
            @(negedge clk);
            if (imm_ready) hs++;
            next();
        end
        imm_valid = 1'b0;
        chk("b2b_accepts", 64'(hs), 64'd4);
        next();

        // div_int=0 gives a period of 65536
        en = 4'b0001; div_int[15:0] = 16'd0; div_frac[7:0] = 8'd0; clkdiv_restart_stb = 4'b0001;
        next();
        clkdiv_restart_stb = '0;
        @(negedge clk); chk("div0_first", 64'(penable[0]), 64'd1); next();
        gap = 0;
        for (int c = 1; c <= 70000; c++) begin
            @(negedge clk);
            if (penable[0]) begin
                gap = c;
                break;
            end
            next();
        end
        chk("div0_period", 64'(gap), 64'd65536);
        next();

        // Asynchronous reset in the middle of HOLD
        stalled = 4'b1000; imm_valid = 1'b1; imm_sm = 2'd3; imm_instr = 16'h5A5A;
        next();
        imm_valid = 1'b0;
        @(negedge clk); chk("prerst_imm", 64'(imm), 64'h8);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("midrst_imm", 64'(imm), 64'd0);
        chk("midrst_ready", 64'(imm_ready), 64'd1);
        chk("midrst_pen", 64'(penable), 64'd0);
        chk("midrst_instr", 64'(imm_instr_o), 64'd0);
        next();
        resetn = 1'b1; stalled = '0; en = 4'b0001; div_int[15:0] = 16'd3;
        @(negedge clk); chk("postrst_pen", 64'(penable[0]), 64'd1);
        next();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                en[i] = ($urandom_range(7) != 0);
                if ($urandom_range(15) == 0) begin
                    div_int[16*i +: 16] = 16'($urandom_range(1, 6));
                    div_frac[8*i +: 8]  = 8'($urandom);
                end
                restart_stb[i]        = ($urandom_range(31) == 0);
                clkdiv_restart_stb[i] = ($urandom_range(31) == 0);
                stalled[i]            = ($urandom_range(2) == 0);
            end
            imm_valid = ($urandom_range(1) == 1);
            imm_sm    = 2'($urandom_range(3));
            imm_instr = 16'($urandom);
            next();
        end
        restart_stb = '0; clkdiv_restart_stb = '0; imm_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
